// File: rtl/point_feeder_pkg.sv
// point_feeder_pkg: FSM state encodings and lane-packing helper
// shared by point_feeder and feeder_skid_buffer.
package point_feeder_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_WAIT  = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // Bit offset of lane i in a packed window; lane 0 sits in the MSBs.
  function automatic int lane_off(
    input int lane,
    input int n,
    input int m
  );
    return (m - 1 - lane) * n;
  endfunction

endpackage

// File: rtl/feeder_skid_buffer.sv
// feeder_skid_buffer: 2-entry valid/ready FIFO, head entry drives outputs.
// Ports: clock, reset (sync, active-low), in_valid/in_data, out_*, count.
module feeder_skid_buffer
  import point_feeder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   cnt;
  logic         pop;

  assign pop       = out_ready && (cnt != 2'd0);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = head;
  assign count     = cnt;

  // The producer never pushes into a full buffer, so no in_ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({in_valid, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_data;
          else             tail <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/point_feeder.sv
// point_feeder: sweeps all M-point windows per CORE_NUMBER query batch.
// Ports: start/size in, mem_rd/addr/rdata, win_* beat out, batch_ack, done.
// Option: FEEDER_ZERO_SKIP_EN masks lanes whose x coordinate is zero.
module point_feeder
  import point_feeder_pkg::*;
#(
  parameter int N           = 16,
  parameter int M           = 32,
  parameter int CORE_NUMBER = 2,
  parameter int ADDR_W      = 15,
  parameter int WIN_ADDR_W  = ADDR_W - $clog2(M)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W:0]        point_cloud_size,
  output logic                   mem_rd,
  output logic [WIN_ADDR_W-1:0]  mem_addr,
  input  logic [N*M-1:0]         mem_rdata_x,
  input  logic [N*M-1:0]         mem_rdata_y,
  input  logic [N*M-1:0]         mem_rdata_z,
  output logic [ADDR_W-1:0]      point_pos,
  output logic [CORE_NUMBER-1:0] query_mask,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [N*M-1:0]         win_x,
  output logic [N*M-1:0]         win_y,
  output logic [N*M-1:0]         win_z,
  output logic [ADDR_W-1:0]      win_base,
  output logic [M-1:0]           lane_mask,
  output logic                   win_last,
  input  logic                   batch_ack,
  output logic                   done
);

  localparam int LW = $clog2(M);
  localparam int PW = 3*N*M + ADDR_W + M + 1;
  localparam logic [ADDR_W:0] MAX_PTS = {1'b1, {ADDR_W{1'b0}}};

  state_t                state;
  logic [ADDR_W:0]       size_q;
  logic [WIN_ADDR_W:0]   num_win;
  logic [WIN_ADDR_W:0]   win_cnt;
  logic [WIN_ADDR_W-1:0] addr_q;
  logic                  rd_q;
  logic                  last_q;
  logic [1:0]            occ;
  logic [1:0]            occ_eff;
  logic                  pop;
  logic                  issue;
  logic                  is_last;
  logic [ADDR_W:0]       start_size;
  logic [ADDR_W:0]       round_up;
  logic [ADDR_W:0]       pos_next;
  logic [ADDR_W-1:0]     base_in;
  logic [M-1:0]          mask_in;
  logic [PW-1:0]         push_data;
  logic [PW-1:0]         head_data;

  assign start_size = (point_cloud_size > MAX_PTS) ?
                      MAX_PTS : point_cloud_size;
  assign round_up   = start_size + (ADDR_W+1)'(M - 1);
  assign pos_next   = {1'b0, point_pos} + (ADDR_W+1)'(CORE_NUMBER);

  assign pop     = win_valid && win_ready;
  // A slot freed by this cycle's pop is reusable, which is what
  // sustains one beat per cycle with the consumer always ready.
  assign occ_eff = occ - {1'b0, pop};
  assign issue   = (state == S_FETCH) &&
                   ((occ_eff + {1'b0, rd_q}) < 2'd2);
  assign is_last = (win_cnt == num_win - (WIN_ADDR_W+1)'(1));

  assign mem_rd   = issue;
  assign mem_addr = win_cnt[WIN_ADDR_W-1:0];

  assign base_in = {addr_q, {LW{1'b0}}};

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < M; i++) begin
      mask_in[i] = ({1'b0, base_in} + (ADDR_W+1)'(i)) < size_q;
`ifdef FEEDER_ZERO_SKIP_EN
      if (mem_rdata_x[lane_off(i, N, M) +: N] == '0)
        mask_in[i] = 1'b0;
`endif
    end
  end

  always_comb begin
    query_mask = '0;
    for (int k = 0; k < CORE_NUMBER; k++)
      query_mask[k] =
        ({1'b0, point_pos} + (ADDR_W+1)'(k)) < size_q;
  end

  assign push_data = {mem_rdata_x, mem_rdata_y, mem_rdata_z,
                      base_in, mask_in, last_q};

  assign {win_x, win_y, win_z,
          win_base, lane_mask, win_last} = head_data;

  feeder_skid_buffer #(
    .W (PW)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_q),
    .in_data   (push_data),
    .out_valid (win_valid),
    .out_ready (win_ready),
    .out_data  (head_data),
    .count     (occ)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      size_q    <= '0;
      num_win   <= '0;
      win_cnt   <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      last_q    <= 1'b0;
      point_pos <= '0;
      done      <= 1'b0;
    end else begin
      rd_q <= issue;
      if (issue) begin
        addr_q  <= win_cnt[WIN_ADDR_W-1:0];
        last_q  <= is_last;
        win_cnt <= win_cnt + (WIN_ADDR_W+1)'(1);
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            size_q  <= start_size;
            num_win <= round_up[ADDR_W:LW];
            if (start_size == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              point_pos <= '0;
              win_cnt   <= '0;
              done      <= 1'b0;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (issue && is_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && win_last) state <= S_WAIT;
        end
        S_WAIT: begin
          if (batch_ack) begin
            point_pos <= pos_next[ADDR_W-1:0];
            if (pos_next >= size_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              win_cnt <= '0;
              state   <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_feeder.sv
// tb_point_feeder: directed runs with a beat scoreboard for point_feeder.
// Expected beats are queued at start and popped on each accepted beat.
`timescale 1ns/1ps
module tb_point_feeder;

  localparam int N   = 16;
  localparam int M   = 32;
  localparam int CN  = 2;
  localparam int AW  = 15;
  localparam int WAW = 10;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [M-1:0]  mask;
    logic          last;
    logic [AW-1:0] pos;
    logic [CN-1:0] qm;
  } beat_t;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [AW:0]    point_cloud_size = '0;
  logic           mem_rd;
  logic [WAW-1:0] mem_addr;
  logic [N*M-1:0] mem_rdata_x = '0;
  logic [N*M-1:0] mem_rdata_y = '0;
  logic [N*M-1:0] mem_rdata_z = '0;
  logic [AW-1:0]  point_pos;
  logic [CN-1:0]  query_mask;
  logic           win_valid;
  logic           win_ready = 1'b1;
  logic [N*M-1:0] win_x;
  logic [N*M-1:0] win_y;
  logic [N*M-1:0] win_z;
  logic [AW-1:0]  win_base;
  logic [M-1:0]   lane_mask;
  logic           win_last;
  logic           batch_ack = 1'b0;
  logic           done;

  beat_t          exp_q[$];
  int             passed = 0;
  int             total = 0;
  int             beats = 0;
  int             rd_count = 0;
  logic [M-1:0]   mask_log [4];
  logic [AW-1:0]  last_pos;
  logic [CN-1:0]  last_qm;
  logic           reset_r = 1'b0;
  logic           rand_rdy = 1'b0;
  logic           stall_q = 1'b0;
  logic [N*M-1:0] held_x, held_y, held_z;
  logic [AW-1:0]  held_b;
  logic [M-1:0]   held_m;
  logic           held_l;

  point_feeder dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .point_cloud_size (point_cloud_size),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_rdata_x      (mem_rdata_x),
    .mem_rdata_y      (mem_rdata_y),
    .mem_rdata_z      (mem_rdata_z),
    .point_pos        (point_pos),
    .query_mask       (query_mask),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .win_x            (win_x),
    .win_y            (win_y),
    .win_z            (win_z),
    .win_base         (win_base),
    .lane_mask        (lane_mask),
    .win_last         (win_last),
    .batch_ack        (batch_ack),
    .done             (done)
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] pt(input int axis, input int p);
    case (axis)
      0:       return (p == 5 || p == 40) ? '0 : N'(p + 1);
      1:       return N'(p * 3 + 7);
      default: return N'(p ^ 32'h5a5a);
    endcase
  endfunction

  function automatic logic [N*M-1:0] win_data(input int axis, input int w);
    logic [N*M-1:0] d;
    d = '0;
    for (int i = 0; i < M; i++) d[(M-1-i)*N +: N] = pt(axis, w*M + i);
    return d;
  endfunction

  always @(posedge clock) begin
    if (mem_rd) begin
      mem_rdata_x <= win_data(0, int'(mem_addr));
      mem_rdata_y <= win_data(1, int'(mem_addr));
      mem_rdata_z <= win_data(2, int'(mem_addr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [N*M-1:0] obs,
                      input logic [N*M-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_pass(input int size);
    int nw;
    beat_t b;
    nw = (size + M - 1) / M;
    for (int pos = 0; pos < size; pos += CN) begin
      for (int w = 0; w < nw; w++) begin
        b.base = AW'(w * M);
        b.last = (w == nw - 1);
        b.pos  = AW'(pos);
        for (int i = 0; i < M; i++) begin
          b.mask[i] = (w*M + i < size);
`ifdef FEEDER_ZERO_SKIP_EN
          if (pt(0, w*M + i) == '0) b.mask[i] = 1'b0;
`endif
        end
        for (int k = 0; k < CN; k++) b.qm[k] = (pos + k < size);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic monitor();
    beat_t b;
    if (mem_rd) rd_count++;
    if (!reset) begin
      stall_q = 1'b0;
      return;
    end
    if (stall_q) begin
      chk("hold_valid", 64'(win_valid), 64'(1));
      chk("hold_base", 64'(win_base), 64'(held_b));
      chk("hold_mask", 64'(lane_mask), 64'(held_m));
      chk("hold_last", 64'(win_last), 64'(held_l));
      chkw("hold_x", win_x, held_x);
      chkw("hold_y", win_y, held_y);
      chkw("hold_z", win_z, held_z);
    end
    if (win_valid && win_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 64'(win_base), 64'h0bad);
      end else begin
        b = exp_q.pop_front();
        chk("beat_base", 64'(win_base), 64'(b.base));
        chk("beat_mask", 64'(lane_mask), 64'(b.mask));
        chk("beat_last", 64'(win_last), 64'(b.last));
        chk("beat_pos", 64'(point_pos), 64'(b.pos));
        chk("beat_qmask", 64'(query_mask), 64'(b.qm));
        chkw("beat_x", win_x, win_data(0, int'(b.base) / M));
        chkw("beat_y", win_y, win_data(1, int'(b.base) / M));
        chkw("beat_z", win_z, win_data(2, int'(b.base) / M));
      end
      if (beats < 4) mask_log[beats] = lane_mask;
      last_pos = point_pos;
      last_qm  = query_mask;
      beats++;
    end
    stall_q = win_valid && !win_ready;
    held_x = win_x;
    held_y = win_y;
    held_z = win_z;
    held_b = win_base;
    held_m = lane_mask;
    held_l = win_last;
  endtask

  // One clock: inputs change just after the rising edge,
  // outputs are observed on the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
    reset = reset_r;
    win_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clock);
    monitor();
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_mem_rd"}, 64'(mem_rd), 64'(0));
    chk({p, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({p, "_point_pos"}, 64'(point_pos), 64'(0));
    chk({p, "_query_mask"}, 64'(query_mask), 64'(0));
    chk({p, "_win_valid"}, 64'(win_valid), 64'(0));
    chk({p, "_win_base"}, 64'(win_base), 64'(0));
    chk({p, "_lane_mask"}, 64'(lane_mask), 64'(0));
    chk({p, "_win_last"}, 64'(win_last), 64'(0));
    chk({p, "_done"}, 64'(done), 64'(0));
    chkw({p, "_win_x"}, win_x, '0);
    chkw({p, "_win_y"}, win_y, '0);
    chkw({p, "_win_z"}, win_z, '0);
  endtask

  task automatic launch(input int size);
    push_pass(size);
    beats = 0;
    point_cloud_size = (AW+1)'(size);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic found;
    logic [M-1:0] m0_exp;
    logic [M-1:0] m1_exp;

    repeat (3) step();
    chk_reset("rst");
    reset_r = 1'b1;
    step();
    batch_ack = 1'b1;

    // size 70, consumer always ready: latency 1 to mem_rd, 3 to beat
    launch(70);
    chk("lat_mem_rd", 64'(mem_rd), 64'(1));
    chk("lat_addr0", 64'(mem_addr), 64'(0));
    chk("lat_valid_c1", 64'(win_valid), 64'(0));
    step();
    chk("lat_valid_c2", 64'(win_valid), 64'(0));
    step();
    chk("lat_valid_c3", 64'(win_valid), 64'(1));
    wait_done("a", 3000);
    chk("a_beats", 64'(beats), 64'(105));
    chk("a_win2_mask", 64'(mask_log[2]), 64'h3f);
    chk("a_final_pos", 64'(point_pos), 64'(70));
    chk("a_final_qmask", 64'(query_mask), 64'(0));
    repeat (3) step();
    chk("a_done_hold", 64'(done), 64'(1));

    // size 71: odd tail batch
    launch(71);
    chk("b_done_clr", 64'(done), 64'(0));
    wait_done("b", 3000);
    chk("b_beats", 64'(beats), 64'(108));
    chk("b_last_pos", 64'(last_pos), 64'(70));
    chk("b_last_qmask", 64'(last_qm), 64'(1));

    // size 70 with random backpressure
    rand_rdy = 1'b1;
    launch(70);
    wait_done("c", 8000);
    chk("c_beats", 64'(beats), 64'(105));
    rand_rdy = 1'b0;

    // size 64 with zeroed x at points 5 and 40
    launch(64);
    wait_done("d", 3000);
    chk("d_beats", 64'(beats), 64'(64));
`ifdef FEEDER_ZERO_SKIP_EN
    m0_exp = 32'hffff_ffdf;
    m1_exp = 32'hffff_feff;
`else
    m0_exp = 32'hffff_ffff;
    m1_exp = 32'hffff_ffff;
`endif
    chk("d_win0_mask", 64'(mask_log[0]), 64'(m0_exp));
    chk("d_win1_mask", 64'(mask_log[1]), 64'(m1_exp));

    // reset in FETCH of batch 3, then replay
    launch(70);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (point_pos == 4 && mem_rd && mem_addr == 0) found = 1'b1;
      else step();
    end
    chk("e_reach_b3", 64'(found), 64'(1));
    reset_r = 1'b0;
    step();
    reset_r = 1'b1;
    step();
    chk_reset("e_rst");
    exp_q.delete();
    launch(70);
    wait_done("e", 3000);
    chk("e_beats", 64'(beats), 64'(105));

    // size 0: straight to done, no reads
    reset_r = 1'b0;
    step();
    reset_r = 1'b1;
    step();
    chk("f_done_pre", 64'(done), 64'(0));
    rd_count = 0;
    launch(0);
    step();
    chk("f_done", 64'(done), 64'(1));
    repeat (3) step();
    chk("f_no_mem_rd", 64'(rd_count), 64'(0));
    chk("f_no_beats", 64'(beats), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
